imem_boot_ctrl: RTL and testbench

Boot-load controller and port arbiter for the single-cycle core's instruction memory. It receives a program as a framed byte stream, assembles 32-bit words, and writes them into the instruction memory through its write port. It holds the CPU in reset during loading and then hands the memory read address to the CPU's PC. It sits between the host byte link, the instruction memory, and the core's reset/fetch path.

---
 rtl/imem_boot_ctrl.sv | 167 ++++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: receives a framed byte stream, assembles 32-bit words,
// writes them into instruction memory, and then hands the memory read
// port to the core. The core is held in reset until a load succeeds.
module imem_boot_ctrl #(
  parameter int WORDS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic [31:0]       cpu_pc,
  output logic [31:0]       cpu_instr,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    RUN   = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam logic [7:0] WordsByte = 8'(WORDS);

  state_t            state_q, state_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        wordIdx_q, wordIdx_d;
  logic [1:0]        byteCnt_q, byteCnt_d;
  logic [7:0]        xorSum_q, xorSum_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        errCode_q, errCode_d;

  logic              accept;
  logic              inRun;
  logic              unusedPcBits;

  // The low PC bits select a byte within a word and the high bits lie
  // beyond the memory, so neither participates in the fetch address.
  assign unusedPcBits = ^{cpu_pc[31:ADDR_W+2], cpu_pc[1:0]};

  // Status and handshake outputs decode straight from the state register
  // so there is no added latency between a state change and its effect.
  assign inRun     = (state_q == RUN);
  assign busy      = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
  assign rx_ready  = busy;
  assign accept    = rx_valid && busy;
  assign cpu_rst_n = inRun;
  assign err       = (state_q == ERROR);
  assign err_code  = errCode_q;
  assign mem_we    = we_q && !inRun;
  assign mem_wdata = wdata_q;
  assign mem_addr  = inRun ? cpu_pc[ADDR_W+1:2] : wrAddr_q;
  assign cpu_instr = inRun ? mem_rdata : 32'h0000_0000;

  // State and datapath registers; reset aborts any load in progress but
  // leaves already-written memory words alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= 8'd0;
      wordIdx_q <= 8'd0;
      byteCnt_q <= 2'd0;
      xorSum_q  <= 8'd0;
      asm_q     <= 24'd0;
      wrAddr_q  <= '0;
      we_q      <= 1'b0;
      wdata_q   <= 32'd0;
      errCode_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wordIdx_q <= wordIdx_d;
      byteCnt_q <= byteCnt_d;
      xorSum_q  <= xorSum_d;
      asm_q     <= asm_d;
      wrAddr_q  <= wrAddr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      errCode_q <= errCode_d;
    end
  end

  // Next-state and datapath logic: frame parsing, word assembly, the
  // running checksum, and a one-cycle write strobe per completed word.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wordIdx_d = wordIdx_q;
    byteCnt_d = byteCnt_q;
    xorSum_d  = xorSum_q;
    asm_d     = asm_q;
    wrAddr_d  = wrAddr_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    errCode_d = errCode_q;

    case (state_q)
      IDLE: begin
        if (load_req) state_d = HDR;
      end
      HDR: begin
        if (accept) begin
          if ((rx_data == 8'd0) || (rx_data > WordsByte)) begin
            state_d   = ERROR;
            errCode_d = 2'b01;
          end else begin
            count_d   = rx_data;
            wordIdx_d = 8'd0;
            byteCnt_d = 2'd0;
            xorSum_d  = 8'd0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          asm_d     = {asm_q[15:0], rx_data};
          xorSum_d  = xorSum_q ^ rx_data;
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) begin
            we_d      = 1'b1;
            wdata_d   = {asm_q, rx_data};
            wrAddr_d  = wordIdx_q[ADDR_W-1:0];
            wordIdx_d = wordIdx_q + 8'd1;
            if ((wordIdx_q + 8'd1) == count_q) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          if (rx_data == xorSum_q) begin
            state_d = RUN;
          end else begin
            state_d   = ERROR;
            errCode_d = 2'b10;
          end
        end
      end
      RUN: begin
        if (load_req) state_d = HDR;
      end
      ERROR: begin
        if (load_req) begin
          state_d   = HDR;
          errCode_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: directed test of the boot-load controller with a
// behavioural instruction memory attached to its write/read ports.
module tb_imem_boot_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load_req;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] cpu_pc;
  logic [31:0] cpu_instr;
  logic        cpu_rst_n;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;

  logic [31:0] mem [0:31];
  logic        preload;
  int          weCount;
  int          weBase;
  int          total;
  int          bad;

  imem_boot_ctrl #(.WORDS(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_req  (load_req),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .cpu_pc    (cpu_pc),
    .cpu_instr (cpu_instr),
    .cpu_rst_n (cpu_rst_n),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: combinational read, write on the rising edge.
  // Preload fills it with a recognisable per-address pattern.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hDEAD_0000 | i;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Count write strobes seen by the memory.
  always @(posedge clk) begin
    if (!rst_n && preload) weCount <= 0;
    else if (mem_we) weCount <= weCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one rising edge, after an optional
  // number of idle cycles with rx_valid low.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulseLoad();
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    preload  = 1'b1;
    load_req = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    cpu_pc   = 32'd0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;
    checkOutput("rst_cpu_rst_n", cpu_rst_n, 0);
    checkOutput("rst_rx_ready", rx_ready, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_err_code", err_code, 0);
    checkOutput("rst_cpu_instr", cpu_instr, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_cpu_rst_n", cpu_rst_n, 0);
    checkOutput("idle_rx_ready", rx_ready, 0);

    // Good two-word load, back to back
    pulseLoad();
    checkOutput("hdr_busy", busy, 1);
    checkOutput("hdr_rx_ready", rx_ready, 1);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h20, 0);
    applyStimulus(8'h08, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h05, 0);
    checkOutput("w0_we", mem_we, 1);
    checkOutput("w0_addr", mem_addr, 0);
    checkOutput("w0_data", mem_wdata, 32'h2008_0005);
    applyStimulus(8'h20, 0);
    checkOutput("w0_we_pulse", mem_we, 0);
    applyStimulus(8'h09, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h0A, 0);
    checkOutput("w1_we", mem_we, 1);
    checkOutput("w1_addr", mem_addr, 1);
    checkOutput("w1_data", mem_wdata, 32'h2009_000A);
    checkOutput("csum_busy", busy, 1);
    checkOutput("csum_cpu_rst_n", cpu_rst_n, 0);
    applyStimulus(8'h0E, 0);
    checkOutput("run_cpu_rst_n", cpu_rst_n, 1);
    checkOutput("run_busy", busy, 0);
    checkOutput("run_mem_we", mem_we, 0);
    checkOutput("run_pc0_addr", mem_addr, 0);
    checkOutput("run_pc0_instr", cpu_instr, 32'h2008_0005);
    cpu_pc = 32'd4;
    #1;
    checkOutput("run_pc4_addr", mem_addr, 1);
    checkOutput("run_pc4_instr", cpu_instr, 32'h2009_000A);
    cpu_pc = 32'd7;
    #1;
    checkOutput("run_pc7_addr", mem_addr, 1);
    checkOutput("good_mem2", mem[2], 32'hDEAD_0002);
    checkOutput("good_we_count", weCount, 2);
    cpu_pc = 32'd0;

    // Reload a one-word frame from RUN
    pulseLoad();
    checkOutput("reload_cpu_rst_n", cpu_rst_n, 0);
    checkOutput("reload_cpu_instr", cpu_instr, 0);
    checkOutput("reload_busy", busy, 1);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h33, 0);
    applyStimulus(8'h44, 0);
    applyStimulus(8'h44, 0);
    checkOutput("reload_run", cpu_rst_n, 1);
    checkOutput("reload_mem0", mem[0], 32'h1122_3344);
    checkOutput("reload_mem1", mem[1], 32'h2009_000A);
    checkOutput("reload_instr0", cpu_instr, 32'h1122_3344);

    // Bad checksum: both words written, then ERROR with code 10
    weBase = weCount;
    pulseLoad();
    applyStimulus(8'h02, 0);
    applyStimulus(8'h20, 0);
    applyStimulus(8'h08, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h05, 0);
    applyStimulus(8'h20, 0);
    applyStimulus(8'h09, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h0A, 0);
    applyStimulus(8'h0F, 0);
    checkOutput("badcs_err", err, 1);
    checkOutput("badcs_code", err_code, 2'b10);
    checkOutput("badcs_cpu_rst_n", cpu_rst_n, 0);
    checkOutput("badcs_busy", busy, 0);
    checkOutput("badcs_writes", weCount - weBase, 2);
    checkOutput("badcs_mem0", mem[0], 32'h2008_0005);
    pulseLoad();
    checkOutput("clear_err", err, 0);
    checkOutput("clear_code", err_code, 0);
    checkOutput("clear_busy", busy, 1);

    // Bad count 00 (already in HDR), then 0x21
    weBase = weCount;
    applyStimulus(8'h00, 0);
    checkOutput("cnt0_err", err, 1);
    checkOutput("cnt0_code", err_code, 2'b01);
    checkOutput("cnt0_cpu_rst_n", cpu_rst_n, 0);
    pulseLoad();
    applyStimulus(8'h21, 0);
    checkOutput("cnt21_err", err, 1);
    checkOutput("cnt21_code", err_code, 2'b01);
    @(posedge clk);
    #1;
    checkOutput("cnt_no_writes", weCount - weBase, 0);

    // Stalled frame; load_req held high mid-frame must be ignored
    pulseLoad();
    applyStimulus(8'h02, $urandom_range(0, 3));
    load_req = 1'b1;
    applyStimulus(8'hA1, $urandom_range(0, 3));
    applyStimulus(8'hB2, $urandom_range(0, 3));
    applyStimulus(8'hC3, $urandom_range(0, 3));
    applyStimulus(8'hD4, $urandom_range(0, 3));
    applyStimulus(8'h01, $urandom_range(1, 3));
    applyStimulus(8'h02, $urandom_range(0, 3));
    applyStimulus(8'h03, $urandom_range(0, 3));
    applyStimulus(8'h04, $urandom_range(0, 3));
    checkOutput("stall_busy", busy, 1);
    load_req = 1'b0;
    applyStimulus(8'h00, $urandom_range(1, 3));
    checkOutput("stall_run", cpu_rst_n, 1);
    checkOutput("stall_err", err, 0);
    checkOutput("stall_mem0", mem[0], 32'hA1B2_C3D4);
    checkOutput("stall_mem1", mem[1], 32'h0102_0304);

    // Asynchronous reset after six payload bytes
    pulseLoad();
    applyStimulus(8'h02, 0);
    applyStimulus(8'h55, 0);
    applyStimulus(8'h66, 0);
    applyStimulus(8'h77, 0);
    applyStimulus(8'h88, 0);
    applyStimulus(8'h99, 0);
    applyStimulus(8'hAA, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_rx_ready", rx_ready, 0);
    checkOutput("abort_mem_we", mem_we, 0);
    checkOutput("abort_mem_addr", mem_addr, 0);
    checkOutput("abort_cpu_rst_n", cpu_rst_n, 0);
    checkOutput("abort_mem0", mem[0], 32'h5566_7788);
    checkOutput("abort_mem1", mem[1], 32'h0102_0304);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_idle_busy", busy, 0);
    checkOutput("abort_idle_cpu", cpu_rst_n, 0);
    checkOutput("abort_idle_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
